ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/bitty_defs_pkg.sv | 22 ++
 rtl/ex_mdu.sv | 169 ++++++++++++++++
 tb/tb_ex_mdu.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_defs_pkg.sv
// Shared encodings for the bitty execute units: RV M-extension funct3 values
// and the multiply/divide unit state encoding.
package bitty_defs;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up applied on the final iteration.
//
// state | meaning
// IDLE  | waiting for start_i; accepts and latches an operation
// CALC  | XLEN radix-2 iterations in progress, pipeline held
// DONE  | one-cycle result strobe, then back to IDLE
module ex_mdu
    import bitty_defs::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      wd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      wd_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [4:0]        wd_q, wd_d;
    logic [XLEN-1:0]   result_q, result_d;

    md_op_e            op_in;
    logic              a_sgn, b_sgn, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, short_res;
    logic [XLEN:0]     mul_sum, div_tmp, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

    // Operand decode at accept time
    always_comb begin
        op_in    = md_op_e'(op_i);
        a_sgn    = rs1_i[XLEN-1] & (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        b_sgn    = rs2_i[XLEN-1] & (op_in inside {MD_MULH, MD_DIV, MD_REM});
        a_mag    = a_sgn ? -rs1_i : rs1_i;
        b_mag    = b_sgn ? -rs2_i : rs2_i;
        div_zero = op_i[2] & (rs2_i == '0);
        div_ovf  = (op_in inside {MD_DIV, MD_REM}) & (rs1_i == INT_MIN) & (rs2_i == '1);
        if (div_zero) begin
            short_res = (op_in inside {MD_DIV, MD_DIVU}) ? '1 : rs1_i;
        end else begin
            short_res = (op_in == MD_DIV) ? rs1_i : '0;
        end
    end

    // One radix-2 step; acc holds {hi, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_tmp   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_tmp - {1'b0, opb_q};
        div_ge    = ~div_diff[XLEN];
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};
        iter_next = op_q[2] ? div_next : mul_next;

        prod_fix  = neg_q ? -iter_next : iter_next;
        quo_fix   = neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
        rem_fix   = rneg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                        fin_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               fin_res = quo_fix;
            default:                       fin_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        result_d = result_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d   = op_in;
                    wd_d   = wd_i;
                    neg_d  = a_sgn ^ b_sgn;
                    rneg_d = a_sgn;
                    if (op_i[2]) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        opb_d = b_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_mag};
                        opb_d = a_mag;
                    end
                    if (div_zero || div_ovf) begin
                        result_d = short_res;
                        cnt_d    = '0;
                        state_d  = MD_DONE;
                    end else begin
                        cnt_d    = CNTW'(XLEN);
                        state_d  = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    acc_d = iter_next;
                    cnt_d = cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        result_d = fin_res;
                        state_d  = MD_DONE;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_MUL;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            wd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            result_q <= result_d;
        end
    end

    // Reset masks the handshake outputs so a held start_i cannot raise stall
    assign stall_o  = !rst && ((state_q == MD_CALC) ||
                               (state_q == MD_IDLE && start_i && !flush_i));
    assign valid_o  = !rst && (state_q == MD_DONE) && !flush_i;
    assign result_o = result_q;
    assign wd_o     = wd_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: directed corner cases, flush/reset behaviour and random
// operations checked against a plain-arithmetic RV32M reference model.
module tb_ex_mdu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i, rs2_i;
    logic [4:0]      wd_i;
    logic            flush_i;
    logic            stall_o, valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      wd_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .wd_i(wd_i), .flush_i(flush_i),
        .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o), .wd_o(wd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint     sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called #1 after a rising edge; that edge-to-edge window is cycle 0.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd, input bit junk,
                          input logic [31:0] exp_res, input int exp_lat);
        int          got_lat;
        int          stall_bad;
        logic [31:0] res;
        logic [4:0]  wdg;
        got_lat   = 0;
        stall_bad = 0;
        res       = '0;
        wdg       = '0;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; wd_i = wd;
        #1;
        if (stall_o !== 1'b1) stall_bad++;
        for (int n = 1; n <= XLEN + 8 && got_lat == 0; n++) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) begin
                got_lat = n;
                res     = result_o;
                wdg     = wd_o;
                if (stall_o !== 1'b0) stall_bad++;
                start_i = 1'b0;
            end else begin
                if (stall_o !== 1'b1) stall_bad++;
                if (junk) begin
                    start_i = 1'b1;
                    op_i    = 3'($urandom_range(0, 7));
                    rs1_i   = $urandom;
                    rs2_i   = $urandom;
                    wd_i    = 5'($urandom_range(0, 31));
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        chk({tag, ".lat"}, 64'(got_lat), 64'(exp_lat));
        chk({tag, ".res"}, {32'b0, res}, {32'b0, exp_res});
        chk({tag, ".wd"}, {59'b0, wdg}, {59'b0, wd});
        chk({tag, ".stall"}, 64'(stall_bad), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".oneshot"}, {63'b0, valid_o}, 64'd0);
        chk({tag, ".hold"}, {32'b0, result_o}, {32'b0, exp_res});
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b0) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rwd;
        int          seen;

        rst = 1'b1; start_i = 1'b1; flush_i = 1'b0;
        op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; wd_i = 5'd9;
        #1;
        chk("rst.stall_async", {63'b0, stall_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", {63'b0, stall_o}, 64'd0);
        chk("rst.valid", {63'b0, valid_o}, 64'd0);
        chk("rst.result", {32'b0, result_o}, 64'd0);
        chk("rst.wd", {59'b0, wd_o}, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;

        run_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  0, 32'hFFFF_FFEB, 33);
        run_op("mulh_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  0, 32'h4000_0000, 33);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  0, 32'hFFFF_FFFE, 33);
        run_op("mulhsu",    3'd2, 32'hFFFF_FFFF,  32'd2,         5'd6,  1, 32'hFFFF_FFFF, 33);
        run_op("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  0, 32'hFFFF_FFFD, 33);
        run_op("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  0, 32'hFFFF_FFFF, 33);
        run_op("divu",      3'd5, 32'd100,        32'd7,         5'd9,  1, 32'd14,        33);
        run_op("remu",      3'd7, 32'd100,        32'd7,         5'd10, 0, 32'd2,         33);
        run_op("div_zero",  3'd4, 32'd5,          32'd0,         5'd11, 0, 32'hFFFF_FFFF, 1);
        run_op("remu_zero", 3'd7, 32'd5,          32'd0,         5'd12, 0, 32'd5,         1);
        run_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 0, 32'h8000_0000, 1);
        run_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1, 32'h0,         1);

        // Flush mid-CALC, then a fresh op issued the cycle after the flush.
        start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd7; wd_i = 5'd15;
        seen = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (valid_o !== 1'b0) seen++;
        end
        flush_i = 1'b1;
        #1;
        if (valid_o !== 1'b0) seen++;
        chk("flush.no_valid", 64'(seen), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        run_op("flush.restart", 3'd5, 32'd100, 32'd7, 5'd16, 0, 32'd14, 33);

        // Flush landing on the DONE cycle suppresses the strobe.
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5; wd_i = 5'd17;
        for (int n = 1; n <= XLEN + 1; n++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (n == XLEN + 1) flush_i = 1'b1;
        end
        #1;
        chk("flush_done.valid", {63'b0, valid_o}, 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_done.after", {63'b0, valid_o}, 64'd0);
        chk("flush_done.idle", {63'b0, stall_o}, 64'd0);

        // flush_i beats start_i in IDLE.
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2;
        #1;
        chk("prio.stall", {63'b0, stall_o}, 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        watch_no_valid("prio.no_valid", 40);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            rwd = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d.op%0d", i, rop), rop, ra, rb, rwd, bit'($urandom_range(0, 1)),
                   ref_mdu(rop, ra, rb), ref_lat(rop, ra, rb));
        end

        // Reset mid-CALC with start_i still held high.
        run_op("pre_rst", 3'd0, 32'd3, 32'd7, 5'd21, 0, 32'd21, 33);
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; wd_i = 5'd22;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.stall", {63'b0, stall_o}, 64'd0);
        chk("midrst.valid", {63'b0, valid_o}, 64'd0);
        @(posedge clk); #1;
        chk("midrst.result", {32'b0, result_o}, 64'd0);
        chk("midrst.wd", {59'b0, wd_o}, 64'd0);
        chk("midrst.stall2", {63'b0, stall_o}, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        #1;
        chk("midrst.idle", {63'b0, stall_o}, 64'd0);
        watch_no_valid("midrst.no_valid", 40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
